// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: WIDTH bits split into STAGES ripple chunks with a registered carry and valid/ready handshake.
// Build option: define ADDSUB_SATURATE_EN to clamp the result on signed overflow (default: wrap modulo 2^WIDTH).
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_A,
    input  logic [WIDTH-1:0] data_B,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    logic             vld_q [STAGES];
    logic             vld_d [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] bx_q  [STAGES];
    logic [WIDTH-1:0] bx_d  [STAGES];
    logic [WIDTH-1:0] res_q [STAGES];
    logic [WIDTH-1:0] res_d [STAGES];
    logic             cy_q  [STAGES];
    logic             cy_d  [STAGES];

    logic             st_v   [STAGES];
    logic [WIDTH-1:0] st_a   [STAGES];
    logic [WIDTH-1:0] st_bx  [STAGES];
    logic [WIDTH-1:0] st_res [STAGES];
    logic             st_c   [STAGES];
    logic [CHUNK:0]   csum   [STAGES];

    logic [WIDTH-1:0] raw_res;
    logic [WIDTH-1:0] result_d, result_q;
    logic             overflow_d, overflow_q;
    logic             zero_d, zero_q;
    logic             adv;

`ifdef ADDSUB_SATURATE_EN
    function automatic logic [WIDTH-1:0] sat_value(input logic a_neg);
        return a_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    // The whole pipe moves as one unit whenever the output slot is free or being drained.
    assign adv       = ~vld_q[LAST] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[LAST];
    assign result    = result_q;
    assign carry_out = cy_q[LAST];
    assign overflow  = overflow_q;
    assign zero      = zero_q;

    // Stage inputs; operands are zeroed for bubbles so undriven data never reaches the outputs.
    always_comb begin
        st_v[0]   = in_valid;
        st_a[0]   = in_valid ? data_A : '0;
        st_bx[0]  = in_valid ? (data_B ^ {WIDTH{sub}}) : '0;
        st_c[0]   = in_valid & sub;
        st_res[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            st_v[k]   = vld_q[k-1];
            st_a[k]   = a_q[k-1];
            st_bx[k]  = bx_q[k-1];
            st_c[k]   = cy_q[k-1];
            st_res[k] = res_q[k-1];
        end
    end

    // Stage k adds slice k and inserts it into the partial result travelling with the token.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            csum[k]  = {1'b0, st_a[k][k*CHUNK +: CHUNK]} + {1'b0, st_bx[k][k*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, st_c[k]};
            vld_d[k] = st_v[k];
            a_d[k]   = st_a[k];
            bx_d[k]  = st_bx[k];
            cy_d[k]  = csum[k][CHUNK];
            res_d[k] = st_res[k];
            res_d[k][k*CHUNK +: CHUNK] = csum[k][CHUNK-1:0];
        end
    end

    always_comb begin
        raw_res    = res_d[LAST];
        overflow_d = st_a[LAST][WIDTH-1] ^ st_bx[LAST][WIDTH-1] ^ raw_res[WIDTH-1] ^ cy_d[LAST];
`ifdef ADDSUB_SATURATE_EN
        result_d   = overflow_d ? sat_value(st_a[LAST][WIDTH-1]) : raw_res;
`else
        result_d   = raw_res;
`endif
        zero_d     = st_v[LAST] & ~|result_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                bx_q[k]  <= '0;
                res_q[k] <= '0;
                cy_q[k]  <= 1'b0;
            end
            result_q   <= '0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= vld_d[k];
                a_q[k]   <= a_d[k];
                bx_q[k]  <= bx_d[k];
                res_q[k] <= res_d[k];
                cy_q[k]  <= cy_d[k];
            end
            result_q   <= result_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: randomized and corner operands, a plain-arithmetic reference model, and a decoupled output monitor.
module tb_pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
);

    localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    logic             clock = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_A;
    logic [WIDTH-1:0] data_B;
    logic             sub;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_A    (data_A),
        .data_B    (data_B),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             co;
        logic             ov;
        logic             z;
        int               cyc;
        logic             ns;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   or_mode = 0;   // 0: out_ready=1, 1: random, 2: out_ready=0
    bit   front_seen = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Reference: exact unsigned and signed arithmetic, overflow = true result outside the signed range.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        logic [WIDTH:0]          u;
        logic signed [WIDTH+1:0] ta, tb, t;
        exp_t                    e;
        ta = {{2{a[WIDTH-1]}}, a};
        tb = {{2{b[WIDTH-1]}}, b};
        t  = s ? ta - tb : ta + tb;
        u  = s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        e.co  = s ? (a >= b) : u[WIDTH];
        e.res = u[WIDTH-1:0];
        e.ov  = (t[WIDTH+1:WIDTH-1] != 3'b000) && (t[WIDTH+1:WIDTH-1] != 3'b111);
`ifdef ADDSUB_SATURATE_EN
        if (e.ov) e.res = a[WIDTH-1] ? MINN : MAXP;
`endif
        e.z   = (e.res == '0);
        e.cyc = 0;
        e.ns  = 1'b0;
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] rnd();
        logic [63:0] x;
        case ($urandom_range(0, 7))
            0:       x = '0;
            1:       x = '1;
            2:       x = 64'h1 << (WIDTH - 1);
            3:       x = (64'h1 << (WIDTH - 1)) - 64'h1;
            default: x = {$urandom(), $urandom()};
        endcase
        return x[WIDTH-1:0];
    endfunction

    task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        exp_t e;
        e     = model(a, b, s);
        e.cyc = cyc;
        e.ns  = (or_mode == 0);
        q.push_back(e);
    endtask

    // Called at a falling edge; returns at a falling edge after the operand is accepted.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        in_valid = 1'b1;
        data_A = a;
        data_B = b;
        sub = s;
        while (!done) begin
            #1;
            if (in_ready) begin
                push(a, b, s);
                done = 1'b1;
            end else if (n >= 200) begin
                checks++;
                errors++;
                $display("FAIL issue_timeout got in_ready=0 for %0d cycles exp accept", n);
                done = 1'b1;
            end
            n++;
            @(negedge clock);
        end
        in_valid = 1'b0;
        data_A = rnd();
        data_B = rnd();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d tokens outstanding exp 0", q.size());
        end
    endtask

    task automatic reset_check(input string tag);
        #1;
        checks++;
        if ({out_valid, result, carry_out, overflow, zero, in_ready} !== {1'b0, {WIDTH{1'b0}}, 4'b0001}) begin
            errors++;
            $display("FAIL %s got out_valid=%b result=%h co=%b ov=%b z=%b in_ready=%b exp 0/0/0/0/0/1",
                     tag, out_valid, result, carry_out, overflow, zero, in_ready);
        end
    endtask

    always @(negedge clock) begin
        #1;
        if (reset_n) begin
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL in_ready got %b exp %b", in_ready, (!out_valid || out_ready));
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_output got result=%h exp no token", result);
                end else begin
                    mon_e = q[0];
                    checks++;
                    if ({result, carry_out, overflow, zero} !== {mon_e.res, mon_e.co, mon_e.ov, mon_e.z}) begin
                        errors++;
                        $display("FAIL result got %h co=%b ov=%b z=%b exp %h co=%b ov=%b z=%b",
                                 result, carry_out, overflow, zero, mon_e.res, mon_e.co, mon_e.ov, mon_e.z);
                    end
                    if (!front_seen && mon_e.ns && or_mode == 0) begin
                        checks++;
                        if (cyc - mon_e.cyc != STAGES) begin
                            errors++;
                            $display("FAIL latency got %0d exp %0d", cyc - mon_e.cyc, STAGES);
                        end
                    end
                    front_seen = 1'b1;
                    if (out_ready) begin
                        void'(q.pop_front());
                        front_seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int acc;
        reset_n = 1'b0;
        in_valid = 1'b0;
        data_A = '0;
        data_B = '0;
        sub = 1'b0;
        repeat (2) @(negedge clock);
        reset_check("reset_state");
        @(negedge clock);
        reset_n = 1'b1;
        idle(2);

        // Directed corners, streaming with out_ready held high
        issue(MAXP, 1, 1'b0);
        issue(5, 7, 1'b1);
        issue(7, 7, 1'b1);
        issue(ONES, 1, 1'b0);
        issue(MINN, MINN, 1'b0);
        issue(MINN + 3, 0, 1'b1);
        issue(0, MINN, 1'b1);
        issue(MAXP, MINN, 1'b1);
        wait_drain();

        // Full pipe with the output blocked: exactly STAGES tokens get in
        or_mode = 2;
        idle(2);
        acc = 0;
        in_valid = 1'b1;
        repeat (3 * STAGES) begin
            data_A = rnd();
            data_B = rnd();
            sub = 1'($urandom_range(0, 1));
            #1;
            if (in_ready) begin
                push(data_A, data_B, sub);
                acc++;
            end
            @(negedge clock);
        end
        in_valid = 1'b0;
        checks++;
        if (acc != STAGES) begin
            errors++;
            $display("FAIL full_pipe_accepts got %0d exp %0d", acc, STAGES);
        end
        or_mode = 1;
        wait_drain();

        // Back-to-back with random backpressure
        repeat (16) issue(rnd(), rnd(), 1'($urandom_range(0, 1)));
        wait_drain();

        // Reset while tokens are in flight
        repeat (6) issue(rnd(), rnd(), 1'($urandom_range(0, 1)));
        reset_n = 1'b0;
        in_valid = 1'b0;
        reset_check("midstream_reset");
        q.delete();
        front_seen = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        or_mode = 0;
        idle(2);
        issue(32'd12345, 32'd678, 1'b1);
        idle(STAGES + 2);
        wait_drain();

        // Long random run mixing idles and backpressure modes
        for (int i = 0; i < 400; i++) begin
            if (i % 100 == 0) or_mode = (i / 100) % 2;
            if ($urandom_range(0, 3) == 0) idle(1);
            issue(rnd(), rnd(), 1'($urandom_range(0, 1)));
        end
        or_mode = 0;
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
